// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for a 5-stage core: stall/flush/hold enables, EX operand forwarding,
// data-memory wait FSM with timeout, and a saturating stall-cycle counter.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             control_stall,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic mem_wait;
    logic load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        // MEM holds the younger result, so it must win over WB; x0 is hardwired zero.
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign mem_wait = (state_q != S_ERR) && dmem_req && !dmem_ready;

    assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                      ((ex_rd_addr == id_rs1_addr) ||
                       (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));

    assign mem_err      = (state_q == S_ERR);
    assign stall_cycles = stall_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        control_stall = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        fwd_a         = fwd_sel(ex_rs1_addr, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b         = fwd_sel(ex_rs2_addr, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;

        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            control_stall = 1'b1;
            fwd_a         = 2'b00;
            fwd_b         = 2'b00;
        end else if (state_q == S_ERR || mem_wait) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            if (state_q != S_ERR) begin
                if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_MEM_WAIT;
                end
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            state_d    = S_RUN;
            wait_cnt_d = '0;
            if (ex_branch_taken) begin
                if_id_flush   = 1'b1;
                control_stall = 1'b1;
            end else if (load_use) begin
                // Single-cycle bubble: the load moves to MEM next cycle and is then forwardable.
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                control_stall = 1'b1;
            end
        end

        stall_d = stall_q;
        if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed hazard scenarios plus a random phase,
// with expected outputs queued at drive time and compared when the DUT output settles.
module tb_hazard_stall_controller;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct {
        logic       rst;
        logic [4:0] id_rs1, id_rs2;
        logic       uses_rs2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_mem_read, br;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic       dreq, drdy;
    } in_t;

    typedef struct {
        logic       pc, ifid, flush, cstall, idex_h, exmem_h, err;
        logic [1:0] fa, fb;
        int         cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, mem_rd, wb_rd;
    logic             id_uses_rs2, ex_mem_read, ex_branch_taken, mem_regwrite, wb_regwrite;
    logic             dmem_req, dmem_ready;
    logic             pc_write, if_id_write, if_id_flush, control_stall, id_ex_hold, ex_mem_hold;
    logic [1:0]       fwd_a, fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Reference model state: 0 run, 1 waiting on memory, 2 error.
    int m_state = 0;
    int m_wait  = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_uses_rs2(id_uses_rs2),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .control_stall(control_stall), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t s;
        s = '{rst: 1'b0, id_rs1: 5'd1, id_rs2: 5'd2, uses_rs2: 1'b1, ex_rs1: 5'd3, ex_rs2: 5'd4,
              ex_rd: 5'd9, ex_mem_read: 1'b0, br: 1'b0, mem_rd: 5'd10, mem_we: 1'b0,
              wb_rd: 5'd11, wb_we: 1'b0, dreq: 1'b0, drdy: 1'b1};
        return s;
    endfunction

    function automatic logic [1:0] ref_fwd(input in_t s, input logic [4:0] rs);
        logic [1:0] r;
        r = 2'b00;
        if (s.wb_we && s.wb_rd != 0 && s.wb_rd == rs) r = 2'b01;
        if (s.mem_we && s.mem_rd != 0 && s.mem_rd == rs) r = 2'b10;
        return r;
    endfunction

    // Drive one cycle: apply inputs, queue the model's expectation, compare once outputs settle,
    // then advance the model to what the rising edge should produce.
    task automatic drive(input in_t s);
        exp_t e, g;
        logic lu;
        @(negedge clk);
        rst = s.rst; id_rs1_addr = s.id_rs1; id_rs2_addr = s.id_rs2; id_uses_rs2 = s.uses_rs2;
        ex_rs1_addr = s.ex_rs1; ex_rs2_addr = s.ex_rs2; ex_rd_addr = s.ex_rd;
        ex_mem_read = s.ex_mem_read; ex_branch_taken = s.br; mem_rd = s.mem_rd;
        mem_regwrite = s.mem_we; wb_rd = s.wb_rd; wb_regwrite = s.wb_we;
        dmem_req = s.dreq; dmem_ready = s.drdy;

        lu = s.ex_mem_read && s.ex_rd != 0 &&
             (s.ex_rd == s.id_rs1 || (s.uses_rs2 && s.ex_rd == s.id_rs2));
        e = '{pc: 1'b1, ifid: 1'b1, flush: 1'b0, cstall: 1'b0, idex_h: 1'b0, exmem_h: 1'b0,
              err: (m_state == 2), fa: ref_fwd(s, s.ex_rs1), fb: ref_fwd(s, s.ex_rs2), cnt: m_cnt};
        if (s.rst) begin
            e.pc = 0; e.ifid = 0; e.cstall = 1; e.fa = 2'b00; e.fb = 2'b00;
        end else if (m_state == 2 || (s.dreq && !s.drdy)) begin
            e.pc = 0; e.ifid = 0; e.idex_h = 1; e.exmem_h = 1;
        end else if (s.br) begin
            e.flush = 1; e.cstall = 1;
        end else if (lu) begin
            e.pc = 0; e.ifid = 0; e.cstall = 1;
        end
        exp_q.push_back(e);

        #1;
        g = exp_q.pop_front();
        check("pc_write", pc_write, g.pc);
        check("if_id_write", if_id_write, g.ifid);
        check("if_id_flush", if_id_flush, g.flush);
        check("control_stall", control_stall, g.cstall);
        check("id_ex_hold", id_ex_hold, g.idex_h);
        check("ex_mem_hold", ex_mem_hold, g.exmem_h);
        check("fwd_a", fwd_a, g.fa);
        check("fwd_b", fwd_b, g.fb);
        check("mem_err", mem_err, g.err);
        check("stall_cycles", stall_cycles, g.cnt);

        if (s.rst) begin
            m_state = 0; m_wait = 0; m_cnt = 0;
        end else begin
            if (!g.pc && m_cnt < CNT_MAX) m_cnt++;
            if (m_state != 2) begin
                if (s.dreq && !s.drdy) begin
                    m_state = (m_wait == MEM_TIMEOUT - 1) ? 2 : 1;
                    m_wait++;
                end else begin
                    m_state = 0; m_wait = 0;
                end
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t s;

        s = idle(); s.rst = 1'b1;
        drive(s); drive(s);
        s = idle();
        drive(s);

        // Load-use on rs1: one bubble, then the load has left EX.
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 5; s.id_rs1 = 5;
        drive(s);
        check("lu_bubble_pc", pc_write, 1'b0);
        s = idle(); s.mem_rd = 5; s.mem_we = 1; s.ex_rs1 = 5;
        drive(s);
        check("lu_after_fwd", fwd_a, 2'b10);

        // x0 destination never stalls; rs2 only matters when it is actually read.
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 0; s.id_rs1 = 0;
        drive(s);
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 6; s.id_rs2 = 6; s.uses_rs2 = 0;
        drive(s);
        s.uses_rs2 = 1;
        drive(s);

        // Taken branch outranks a coincident load-use.
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 5; s.id_rs1 = 5; s.br = 1;
        drive(s);
        check("br_flush", if_id_flush, 1'b1);

        // Three memory wait cycles from a cleared counter, then completion.
        s = idle(); s.rst = 1; drive(s);
        s = idle(); s.dreq = 1; s.drdy = 0;
        repeat (3) drive(s);
        s.drdy = 1;
        drive(s);
        check("wait3_count", stall_cycles, 32'd3);
        check("wait3_pc", pc_write, 1'b1);
        s = idle(); drive(s);

        // Forwarding priority and x0 suppression.
        s = idle(); s.ex_rs1 = 7; s.mem_rd = 7; s.wb_rd = 7; s.mem_we = 1; s.wb_we = 1;
        drive(s);
        check("fwd_mem_wins", fwd_a, 2'b10);
        s.mem_we = 0; drive(s);
        s.ex_rs1 = 0; s.mem_rd = 0; s.wb_rd = 0; s.mem_we = 1; drive(s);
        s = idle(); s.ex_rs2 = 12; s.wb_rd = 12; s.wb_we = 1; drive(s);

        // Timeout into ERR, which then ignores dmem_ready; counter saturates; reset clears.
        s = idle(); s.dreq = 1; s.drdy = 0;
        repeat (MEM_TIMEOUT) drive(s);
        s = idle();
        drive(s);
        check("timeout_err", mem_err, 1'b1);
        check("timeout_hold", ex_mem_hold, 1'b1);
        repeat (12) drive(s);
        check("cnt_saturated", stall_cycles, CNT_MAX);
        s.rst = 1; drive(s);
        s.rst = 0; drive(s);
        check("rst_clears_err", mem_err, 1'b0);
        check("rst_clears_cnt", stall_cycles, 32'd0);

        // Random traffic over small register indices to provoke hazards often.
        for (int i = 0; i < 300; i++) begin
            s = idle();
            s.id_rs1 = 5'($urandom_range(0, 3)); s.id_rs2 = 5'($urandom_range(0, 3));
            s.uses_rs2 = 1'($urandom); s.ex_rs1 = 5'($urandom_range(0, 3));
            s.ex_rs2 = 5'($urandom_range(0, 3)); s.ex_rd = 5'($urandom_range(0, 3));
            s.ex_mem_read = 1'($urandom); s.br = ($urandom_range(0, 5) == 0);
            s.mem_rd = 5'($urandom_range(0, 3)); s.mem_we = 1'($urandom);
            s.wb_rd = 5'($urandom_range(0, 3)); s.wb_we = 1'($urandom);
            s.dreq = ($urandom_range(0, 3) == 0); s.drdy = 1'($urandom);
            s.rst = ($urandom_range(0, 60) == 0);
            drive(s);
        end

        if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
